// File: rtl/usb_sniffer_mem_pkg.sv
// Shared definitions for the sniffer memory-request arbiter.
// Holds the requester ID encoding used in the ID FIFO and the default
// outstanding-transaction depth, which matches the bridge response tracker.
package usb_sniffer_mem_pkg;

  localparam logic REQ_CAPTURE = 1'b0;
  localparam logic REQ_HOST    = 1'b1;

  localparam int OUTSTANDING_DEFAULT   = 16;
  localparam int OUTSTANDING_W_DEFAULT = 4;

endpackage

// File: rtl/usb_sniffer_mem_arb_fifo.sv
// In-order requester-ID FIFO, one bit wide.
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset
//   push_i/data_i push a requester ID (ignored when full)
//   accept_o      FIFO has room; derived from the registered count only
//   pop_i         drop the head entry (ignored when empty)
//   valid_o       FIFO holds at least one entry
//   data_o        head entry (owner of the oldest outstanding transaction)
module usb_sniffer_mem_arb_fifo #(
  parameter int DEPTH   = 16,
  parameter int DEPTH_W = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic data_i,
  output logic accept_o,
  input  logic pop_i,
  output logic valid_o,
  output logic data_o
);

  localparam logic [DEPTH_W:0]   FULL_CNT = (DEPTH_W+1)'(DEPTH);
  localparam logic [DEPTH_W-1:0] LAST_PTR = DEPTH_W'(DEPTH - 1);

  logic [DEPTH-1:0]   ids_q;
  logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign accept_o = (count_q != FULL_CNT);
  assign valid_o  = (count_q != '0);
  assign data_o   = ids_q[rd_ptr_q];

  assign do_push = push_i & accept_o;
  assign do_pop  = pop_i & valid_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: entries are only read while counted valid.
  always_ff @(posedge clk_i) begin
    if (do_push) ids_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/usb_sniffer_mem_arb.sv
// Two-requester arbiter in front of the sniffer AXI bridge inport.
// Requester 0 is the capture writer, requester 1 the host readback path.
// Requests are forwarded combinationally with round-robin tie breaking and
// a grant lock while the bridge stalls; an ID FIFO routes each bridge
// response back to the requester that issued it.
// Ports:
//   reqN_*           request in (wr strobes, rd, len, addr, write data),
//                    accept/ack/error/read data out
//   mem_*            request out to the bridge, accept/ack/error/data in
//   unexpected_ack_o pulse when the bridge acks with nothing outstanding
module usb_sniffer_mem_arb
  import usb_sniffer_mem_pkg::*;
#(
  parameter int OUTSTANDING   = OUTSTANDING_DEFAULT,
  parameter int OUTSTANDING_W = OUTSTANDING_W_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  req0_wr_i,
  input  logic        req0_rd_i,
  input  logic [7:0]  req0_len_i,
  input  logic [31:0] req0_addr_i,
  input  logic [31:0] req0_write_data_i,
  output logic        req0_accept_o,
  output logic        req0_ack_o,
  output logic        req0_error_o,
  output logic [31:0] req0_read_data_o,
  input  logic [3:0]  req1_wr_i,
  input  logic        req1_rd_i,
  input  logic [7:0]  req1_len_i,
  input  logic [31:0] req1_addr_i,
  input  logic [31:0] req1_write_data_i,
  output logic        req1_accept_o,
  output logic        req1_ack_o,
  output logic        req1_error_o,
  output logic [31:0] req1_read_data_o,
  output logic [3:0]  mem_wr_o,
  output logic        mem_rd_o,
  output logic [7:0]  mem_len_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_write_data_o,
  input  logic        mem_accept_i,
  input  logic        mem_ack_i,
  input  logic        mem_error_i,
  input  logic [31:0] mem_read_data_i,
  output logic        unexpected_ack_o
);

  logic act0, act1, grant, grant_act;
  logic grant_q, grant_d, lock_q, lock_d, last_q, last_d;
  logic fifo_accept, fifo_valid, owner;
  logic fwd, take, ack_ok;

  assign act0 = req0_rd_i | (|req0_wr_i);
  assign act1 = req1_rd_i | (|req1_wr_i);

  // A locked grant holds the stalled requester on the bus; on a tie the
  // requester that did not win last time goes next.
  always_comb begin
    grant = grant_q;
    if (lock_q)            grant = grant_q;
    else if (act0 && act1) grant = ~last_q;
    else if (act0)         grant = REQ_CAPTURE;
    else if (act1)         grant = REQ_HOST;
  end

  assign grant_act = (grant == REQ_HOST) ? act1 : act0;
  // All outputs are held low while in reset, so every path is gated by rst_i.
  assign fwd  = grant_act & fifo_accept & ~rst_i;
  assign take = fwd & mem_accept_i;

  assign mem_wr_o         = fwd ? ((grant == REQ_HOST) ? req1_wr_i : req0_wr_i) : '0;
  assign mem_rd_o         = fwd ? ((grant == REQ_HOST) ? req1_rd_i : req0_rd_i) : 1'b0;
  assign mem_len_o        = fwd ? ((grant == REQ_HOST) ? req1_len_i : req0_len_i) : '0;
  assign mem_addr_o       = fwd ? ((grant == REQ_HOST) ? req1_addr_i : req0_addr_i) : '0;
  assign mem_write_data_o = fwd ? ((grant == REQ_HOST) ? req1_write_data_i
                                                       : req0_write_data_i) : '0;

  assign req0_accept_o = take & (grant == REQ_CAPTURE);
  assign req1_accept_o = take & (grant == REQ_HOST);

  always_comb begin
    grant_d = grant_q;
    lock_d  = lock_q;
    last_d  = last_q;
    if (take) begin
      grant_d = grant;
      last_d  = grant;
      lock_d  = 1'b0;
    end else if (grant_act && !rst_i) begin
      // Held request not taken (bridge stall or FIFO full): freeze the grant.
      grant_d = grant;
      lock_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_q <= REQ_CAPTURE;
      lock_q  <= 1'b0;
      last_q  <= REQ_HOST;
    end else begin
      grant_q <= grant_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
    end
  end

  usb_sniffer_mem_arb_fifo #(
    .DEPTH   (OUTSTANDING),
    .DEPTH_W (OUTSTANDING_W)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (take),
    .data_i   (grant),
    .accept_o (fifo_accept),
    .pop_i    (ack_ok),
    .valid_o  (fifo_valid),
    .data_o   (owner)
  );

  // Responses return in issue order, so the FIFO head owns the current ack.
  assign ack_ok           = mem_ack_i & fifo_valid & ~rst_i;
  assign unexpected_ack_o = mem_ack_i & ~fifo_valid & ~rst_i;

  assign req0_ack_o       = ack_ok & (owner == REQ_CAPTURE);
  assign req1_ack_o       = ack_ok & (owner == REQ_HOST);
  assign req0_error_o     = req0_ack_o & mem_error_i;
  assign req1_error_o     = req1_ack_o & mem_error_i;
  assign req0_read_data_o = req0_ack_o ? mem_read_data_i : '0;
  assign req1_read_data_o = req1_ack_o ? mem_read_data_i : '0;

endmodule
